imem_loader: RTL and testbench

- Writer side of the instruction memory: fills instruction memory from a byte stream (debug link / testbench driver) while the single-cycle core is held off.
- The core's fetch path is the reader of the same memory.
- Accepts a 2-byte word-count header, then assembles 4 bytes per instruction, little-endian.
- Issues one write per word at consecutive word addresses starting at 0, and asserts cpu_hold for the whole load.

---
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. While the core is held off through
//   cpu_hold, a byte stream supplies a 16-bit little-endian word count followed
//   by 4 little-endian bytes per instruction. Each assembled instruction is
//   written to consecutive word addresses starting at 0. Words beyond the
//   memory depth are still consumed to keep the stream aligned, but they are
//   not written, and the sticky overflow flag is raised.
//
// Ports
//   clk, rst      : clock and asynchronous active-high reset
//   start         : one-cycle pulse, begins a load when idle
//   in_valid/in_data/in_ready : byte stream, accepted on valid && ready
//   imem_w_en/imem_w_addr/imem_w_data : instruction memory write port
//   cpu_hold      : high while loading; the top level ORs it into core reset
//   busy          : high in every state except IDLE
//   done          : one-cycle pulse when the load completes
//   overflow      : sticky, header count exceeded IMEM_DEPTH_WORDS
//   words_loaded  : number of words actually written in this or the last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int INSTRUCTION_WIDTH    = 32,
  parameter int IMEM_WORD_ADDR_WIDTH = 8,
  parameter int IMEM_DEPTH_WORDS     = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic [7:0]                      in_data,
  output logic                            in_ready,
  output logic                            imem_w_en,
  output logic [IMEM_WORD_ADDR_WIDTH-1:0] imem_w_addr,
  output logic [INSTRUCTION_WIDTH-1:0]    imem_w_data,
  output logic                            cpu_hold,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow,
  output logic [15:0]                     words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_LO = 3'd1;
  localparam logic [2:0] S_HDR_HI = 3'd2;
  localparam logic [2:0] S_WORD   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // One extra bit so a depth of exactly 65536 still compares correctly.
  localparam logic [16:0] DEPTH_LIMIT = 17'(IMEM_DEPTH_WORDS);

  logic [2:0]  state;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;   // bytes 0..2; byte 3 goes straight to imem_w_data

  logic        accept;
  logic        in_range;
  logic [15:0] next_idx;

  assign accept   = in_valid && in_ready;
  assign in_range = {1'b0, word_idx} < DEPTH_LIMIT;
  assign next_idx = word_idx + 16'd1;

  // Status outputs are pure decodes of the state register.
  // NOTE: every signal driven in always_comb gets a default first so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    case (state)
      S_HDR_LO, S_HDR_HI, S_WORD: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      S_WRITE: cpu_hold = 1'b1;
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      count        <= '0;
      word_idx     <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
      imem_w_en    <= 1'b0;
      imem_w_addr  <= '0;
      imem_w_data  <= '0;
      overflow     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_w_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow     <= 1'b0;
            words_loaded <= '0;
            word_idx     <= '0;
            byte_idx     <= '0;
            state        <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            state      <= S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            state       <= ({in_data, count[7:0]} == 16'd0) ? S_DONE : S_WORD;
          end
        end
        S_WORD: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                // Last byte: present the write during the WRITE cycle so the
                // memory captures it on the edge that ends WRITE.
                state <= S_WRITE;
                if (in_range) begin
                  imem_w_en   <= 1'b1;
                  imem_w_addr <= word_idx[IMEM_WORD_ADDR_WIDTH-1:0];
                  imem_w_data <= {in_data, word_buf};
                end
              end
            endcase
          end
        end
        S_WRITE: begin
          if (in_range) words_loaded <= words_loaded + 16'd1;
          else          overflow     <= 1'b1;
          word_idx <= next_idx;
          byte_idx <= '0;
          state    <= (next_idx == count) ? S_DONE : S_WORD;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader (instantiated with a 4-word memory so
//   overflow is reachable). Streams are built as byte queues; the expected
//   writes are derived directly from the stream contents (count header, then
//   little-endian words, only the first IMEM_DEPTH_WORDS stored).
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_w_en;
  logic [AW-1:0] imem_w_addr;
  logic [31:0] imem_w_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] words_loaded;

  imem_loader #(
    .INSTRUCTION_WIDTH   (32),
    .IMEM_WORD_ADDR_WIDTH(AW),
    .IMEM_DEPTH_WORDS    (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .imem_w_en   (imem_w_en),
    .imem_w_addr (imem_w_addr),
    .imem_w_data (imem_w_data),
    .cpu_hold    (cpu_hold),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Write/done monitor, sampled on the falling edge.
  logic [7:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    if (imem_w_en) begin
      wr_addr_q.push_back(imem_w_addr);
      wr_data_q.push_back(imem_w_data);
      check("ready_low_in_write", {31'd0, in_ready}, 32'd0);
    end
    if (done) begin
      done_cnt++;
      check("hold_low_at_done", {31'd0, cpu_hold}, 32'd0);
    end
  end

  logic [7:0] stream[$];

  task automatic make_stream(input int cnt);
    stream.delete();
    stream.push_back(8'(cnt));
    stream.push_back(8'(cnt >> 8));
    for (int i = 0; i < 4 * cnt; i++) stream.push_back(8'($urandom_range(255, 0)));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // Offer one byte after a random idle gap; returns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    bit accepted = 1'b0;
    int gap = $urandom_range(max_gap, 0);
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
    end
    if (!accepted) check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Run the stream in `stream`; optionally pulse start before byte poke_at.
  task automatic run_load(input int max_gap, input int poke_at);
    int cnt;
    int exp_n;
    logic [31:0] exp_word;
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
    pulse_start();
    check("hold_after_start", {31'd0, cpu_hold}, 32'd1);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == poke_at) pulse_start();
      send_byte(stream[i], max_gap);
    end
    // WRITE then DONE follow the final byte: done within two cycles.
    for (int i = 0; i < 2 && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("done_in_time", done_cnt, 32'd1);
    repeat (3) @(negedge clk);
    #1;
    check("done_once", done_cnt, 32'd1);

    cnt   = int'(stream[0]) + 256 * int'(stream[1]);
    exp_n = (cnt < DEPTH) ? cnt : DEPTH;
    check("write_count", wr_addr_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < wr_addr_q.size(); i++) begin
      exp_word = {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]};
      check("write_addr", {24'd0, wr_addr_q[i]}, i);
      check("write_data", wr_data_q[i], exp_word);
    end
    check("words_loaded", {16'd0, words_loaded}, exp_n);
    check("overflow", {31'd0, overflow}, (cnt > DEPTH) ? 32'd1 : 32'd0);
    check("hold_after_done", {31'd0, cpu_hold}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string where);
    check({where, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({where, "_w_en"}, {31'd0, imem_w_en}, 32'd0);
    check({where, "_w_addr"}, {24'd0, imem_w_addr}, 32'd0);
    check({where, "_w_data"}, imem_w_data, 32'd0);
    check({where, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({where, "_busy"}, {31'd0, busy}, 32'd0);
    check({where, "_done"}, {31'd0, done}, 32'd0);
    check({where, "_overflow"}, {31'd0, overflow}, 32'd0);
    check({where, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1;
    check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic two-word load.
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_load(0, -1);

    // Zero count.
    stream = '{8'h00, 8'h00};
    run_load(0, -1);

    // One word with random stalls on in_valid.
    make_stream(1);
    run_load(3, -1);

    // Overflow: six words into a four-word memory.
    make_stream(6);
    run_load(0, -1);

    // Start pulsed mid-WORD is ignored.
    make_stream(3);
    run_load(1, 5);

    // Randomized loads.
    for (int k = 0; k < 6; k++) begin
      make_stream($urandom_range(6, 0));
      run_load($urandom_range(2, 0), -1);
    end

    // Reset after two bytes of word 1: word 0 written, word 1 abandoned.
    make_stream(2);
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(stream[i], 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(negedge clk);
    check("mid_rst_writes", wr_addr_q.size(), 32'd1);
    rst = 1'b0;
    make_stream(2);
    run_load(0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
